// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode encodings, mode type and sequencer state enum.
package alu_pkg;

   typedef logic [4:0] alu_mode_t;

   localparam alu_mode_t ALU_ADD = 5'd0;
   localparam alu_mode_t ALU_AND = 5'd1;
   localparam alu_mode_t ALU_OR  = 5'd2;
   localparam alu_mode_t ALU_EOR = 5'd3;
   localparam alu_mode_t ALU_SR  = 5'd4;
   localparam alu_mode_t ALU_SUB = 5'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } alu_seq_state_t;

   // ADD and SUB are the only modes that chain a real carry and produce V.
   function automatic logic alu_is_arith(input alu_mode_t m);
      return (m == ALU_ADD) || (m == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU: ADD/SUB (SBC convention), AND/OR/EOR, rotate-right.
// Undefined modes pass operand a through and preserve the carry.
module alu
   import alu_pkg::*;
(
   input  alu_mode_t   mode,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic        carry_in,
   output logic [7:0]  result,
   output logic        carry_out,
   output logic        overflow,
   output logic        zero,
   output logic        sign
);

   logic [7:0] b_eff;
   logic [8:0] sum;

   // Mode decode and per-byte result/flag generation.
   always_comb begin
      b_eff     = (mode == ALU_SUB) ? ~b : b;
      sum       = 9'(a) + 9'(b_eff) + 9'(carry_in);
      result    = a;
      carry_out = carry_in;
      overflow  = 1'b0;
      case (mode)
         ALU_ADD, ALU_SUB: begin
            result    = sum[7:0];
            carry_out = sum[8];
            overflow  = (a[7] == b_eff[7]) && (sum[7] != a[7]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_EOR: result = a ^ b;
         ALU_SR: begin
            result    = {carry_in, a[7:1]};
            carry_out = a[0];
         end
         default: ;
      endcase
      zero = (result == 8'd0);
      sign = result[7];
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-byte operation sequencer: runs an 8..32-bit request through one 8-bit
// alu, one byte per cycle, and returns the assembled result with C/V/Z/N.
// Optional feature macro: ALU_SEQ_ABORT_EN adds an 'abort' input that cancels
// a request in flight and blocks accepts while asserted.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 4
)(
   input  logic                   clk,
   input  logic                   reset_n,
`ifdef ALU_SEQ_ABORT_EN
   input  logic                   abort,
`endif
   input  logic                   req_valid,
   output logic                   req_ready,
   input  alu_mode_t              req_mode,
   input  logic [1:0]             req_len,
   input  logic [8*MAX_BYTES-1:0] req_a,
   input  logic [8*MAX_BYTES-1:0] req_b,
   input  logic                   req_carry,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [8*MAX_BYTES-1:0] rsp_data,
   output logic                   rsp_carry,
   output logic                   rsp_overflow,
   output logic                   rsp_zero,
   output logic                   rsp_sign,
   output logic                   busy
);

   localparam int unsigned IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

   alu_seq_state_t            state;
   alu_mode_t                 mode_q;
   logic [1:0]                len_q;
   logic [MAX_BYTES-1:0][7:0] a_q;
   logic [MAX_BYTES-1:0][7:0] b_q;
   logic [MAX_BYTES-1:0][7:0] res_q;
   logic [MAX_BYTES-1:0][7:0] res_next;
   logic [IDX_W-1:0]          idx_q;
   logic                      chain_q;

   logic [7:0] a_byte;
   logic [7:0] b_byte;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       alu_ovf;
   logic       alu_zero;
   logic       alu_sign;
   logic       unused_alu_flags;

   logic       abort_c;
   logic       last_c;
   logic       v_c;
   logic       b_eff7;

`ifdef ALU_SEQ_ABORT_EN
   assign abort_c = abort;
`else
   assign abort_c = 1'b0;
`endif

   // Ready only in IDLE, and never while reset (or abort) is held.
   assign req_ready = reset_n && !abort_c && (state == ST_IDLE);

   // Byte-select mux on the latched operands.
   assign a_byte = a_q[idx_q];
   assign b_byte = b_q[idx_q];

   alu u_alu (
      .mode      (mode_q),
      .a         (a_byte),
      .b         (b_byte),
      .carry_in  (chain_q),
      .result    (alu_result),
      .carry_out (alu_carry),
      .overflow  (alu_ovf),
      .zero      (alu_zero),
      .sign      (alu_sign)
   );

   // The sequencer derives V/Z/N over the full width itself.
   assign unused_alu_flags = ^{alu_ovf, alu_zero, alu_sign};

   // Result register with the current byte merged in.
   always_comb begin
      res_next        = res_q;
      res_next[idx_q] = alu_result;
   end

   // Last byte is the MS byte for upward walks, byte 0 for rotate-right.
   assign last_c = (mode_q == ALU_SR) ? (idx_q == '0) : (idx_q == IDX_W'(len_q));

   // Signed overflow on the MS byte, using the effective (possibly inverted) b.
   assign b_eff7 = (mode_q == ALU_SUB) ? ~b_byte[7] : b_byte[7];
   assign v_c    = alu_is_arith(mode_q) && (a_byte[7] == b_eff7) &&
                   (alu_result[7] != a_byte[7]);

   // FSM, byte counter, carry chain and registered response.
   always_ff @(posedge clk) begin
      if (!reset_n || (abort_c && (state != ST_IDLE))) begin
         state        <= ST_IDLE;
         mode_q       <= ALU_ADD;
         len_q        <= 2'd0;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         idx_q        <= '0;
         chain_q      <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_carry    <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_sign     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  mode_q  <= req_mode;
                  len_q   <= req_len;
                  a_q     <= req_a;
                  b_q     <= req_b;
                  res_q   <= '0;
                  idx_q   <= (req_mode == ALU_SR) ? IDX_W'(req_len) : '0;
                  chain_q <= req_carry;
                  busy    <= 1'b1;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               res_q   <= res_next;
               chain_q <= alu_carry;
               if (last_c) begin
                  rsp_valid    <= 1'b1;
                  rsp_data     <= res_next;
                  rsp_carry    <= alu_carry;
                  rsp_overflow <= v_c;
                  rsp_zero     <= (res_next == '0);
                  rsp_sign     <= res_next[IDX_W'(len_q)][7];
                  state        <= ST_DONE;
               end else if (mode_q == ALU_SR) begin
                  idx_q <= idx_q - IDX_W'(1);
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
